// File: rtl/mesh_wormhole_pkg.sv
// Shared flit-type and arbiter-state encodings for the 2D mesh wormhole router.
// Combinational helpers only; no state and no handshake lives here.
// Imported by every arbiter and selector in the node.
package mesh_wormhole_pkg;

    localparam logic [1:0] FLIT_BODY      = 2'b00;
    localparam logic [1:0] FLIT_HEAD      = 2'b01;
    localparam logic [1:0] FLIT_TAIL      = 2'b10;
    localparam logic [1:0] FLIT_HEAD_TAIL = 2'b11;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // A head opens a path; a single-flit packet both opens and closes it.
    function automatic logic flit_is_head(input logic [1:0] id);
        return (id == FLIT_HEAD) || (id == FLIT_HEAD_TAIL);
    endfunction

    function automatic logic flit_is_tail(input logic [1:0] id);
        return (id == FLIT_TAIL) || (id == FLIT_HEAD_TAIL);
    endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Winner selection: first requester at or after rr_ptr (HOP_PRIO_EN: largest hop count, ties by rr order).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the winner is used.
module rr_prio_select #(
    parameter int IN_N      = 5,
    parameter int HOP_CNT_W = 4
) (
    input  logic [IN_N-1:0]           req,
    input  logic [$clog2(IN_N)-1:0]   rr_ptr,
    input  logic [IN_N*HOP_CNT_W-1:0] hop_count,
    output logic [$clog2(IN_N)-1:0]   winner,
    output logic                      any_req
);

    localparam int PTR_W = $clog2(IN_N);

    int   idx;
    logic found;

`ifdef HOP_PRIO_EN
    logic [HOP_CNT_W-1:0] best_hop;

    // Scan in round-robin order; a strictly larger hop count displaces the
    // current pick, so equal hops keep the earliest one after rr_ptr.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        best_hop = '0;
        idx      = 0;
        for (int k = 0; k < IN_N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= IN_N) begin
                idx = idx - IN_N;
            end
            if (req[idx] && (!found || (hop_count[idx*HOP_CNT_W +: HOP_CNT_W] > best_hop))) begin
                found    = 1'b1;
                winner   = idx[PTR_W-1:0];
                best_hop = hop_count[idx*HOP_CNT_W +: HOP_CNT_W];
            end
        end
    end
`else
    logic unused_hop;
    assign unused_hop = ^hop_count;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < IN_N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= IN_N) begin
                idx = idx - IN_N;
            end
            if (req[idx] && !found) begin
                found  = 1'b1;
                winner = idx[PTR_W-1:0];
            end
        end
    end
`endif

    assign any_req = |req;

endmodule

// File: rtl/wormhole_out_chan_arbiter.sv
// Per-output wormhole arbiter: locks one input to this output from head to tail (HOP_PRIO_EN biases by hop count).
// Latency: head in cycle n -> grant in n+1; tail in t -> next grant no earlier than t+2.
// Backpressure: out_vld_o drops while owner empty or downstream not ready; path, sel and grant held.
module wormhole_out_chan_arbiter
    import mesh_wormhole_pkg::*;
#(
    parameter int IN_N        = 5,
    parameter int OUT_M       = 5,
    parameter int FLIT_ID_W   = 2,
    parameter int HOP_CNT_W   = 4,
    parameter int OUT_CHAN_ID = 0
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [IN_N*$clog2(OUT_M)-1:0]   rtr_res_i,
    input  logic [IN_N-1:0]                 rtr_res_vld_i,
    input  logic [IN_N*HOP_CNT_W-1:0]       hop_count_i,
    input  logic [IN_N*FLIT_ID_W-1:0]       flit_id_i,
    input  logic [IN_N-1:0]                 data_vld_i,
    input  logic                            forward_node_rdy_i,
    output logic [$clog2(IN_N)-1:0]         sel_o,
    output logic                            out_vld_o,
    output logic [IN_N-1:0]                 chan_alloc_o
);

    localparam int                RES_W  = $clog2(OUT_M);
    localparam int                PTR_W  = $clog2(IN_N);
    localparam logic [RES_W-1:0]  OUT_ID = RES_W'(OUT_CHAN_ID);

    arb_state_t          state, state_nxt;
    logic [PTR_W-1:0]    owner, owner_nxt;
    logic [PTR_W-1:0]    rr_ptr, rr_ptr_nxt;
    logic [PTR_W-1:0]    winner;
    logic [IN_N-1:0]     grant, grant_nxt;
    logic [IN_N-1:0]     req;
    logic                any_req;
    logic                owner_vld;
    logic [FLIT_ID_W-1:0] owner_flit;

    always_comb begin
        req = '0;
        for (int i = 0; i < IN_N; i++) begin
            req[i] = data_vld_i[i] & rtr_res_vld_i[i]
                   & (rtr_res_i[i*RES_W +: RES_W] == OUT_ID)
                   & flit_is_head(flit_id_i[i*FLIT_ID_W +: FLIT_ID_W]);
        end
    end

    rr_prio_select #(
        .IN_N      (IN_N),
        .HOP_CNT_W (HOP_CNT_W)
    ) u_select (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .hop_count (hop_count_i),
        .winner    (winner),
        .any_req   (any_req)
    );

    // Owner's head-of-queue view, muxed from the registered owner index.
    always_comb begin
        owner_vld  = 1'b0;
        owner_flit = '0;
        for (int i = 0; i < IN_N; i++) begin
            if (owner == PTR_W'(i)) begin
                owner_vld  = data_vld_i[i];
                owner_flit = flit_id_i[i*FLIT_ID_W +: FLIT_ID_W];
            end
        end
    end

    assign out_vld_o    = (state == ARB_BUSY) & owner_vld & forward_node_rdy_i;
    assign sel_o        = owner;
    assign chan_alloc_o = grant;

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        grant_nxt  = grant;
        case (state)
            ARB_IDLE: begin
                if (any_req) begin
                    state_nxt         = ARB_BUSY;
                    owner_nxt         = winner;
                    grant_nxt         = '0;
                    grant_nxt[winner] = 1'b1;
                end
            end
            ARB_BUSY: begin
                // Any non-tail flit, including a stray head, just rides the open path.
                if (out_vld_o && flit_is_tail(owner_flit)) begin
                    state_nxt  = ARB_IDLE;
                    grant_nxt  = '0;
                    rr_ptr_nxt = (owner == PTR_W'(IN_N - 1)) ? '0 : owner + PTR_W'(1);
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= ARB_IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            grant  <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_ptr_nxt;
            grant  <= grant_nxt;
        end
    end

    a_grant_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(chan_alloc_o));
    a_vld_has_grant: assert property (@(posedge clk_i) disable iff (!rst_ni) out_vld_o |-> (|chan_alloc_o));

endmodule

// File: tb/tb_wormhole_out_chan_arbiter.sv
// Directed bench: per-input flit buffers feed the arbiter; a packet-level model predicts every cycle.
module tb_wormhole_out_chan_arbiter;

    localparam int IN_N   = 5;
    localparam int OUT_M  = 5;
    localparam int FW     = 2;
    localparam int HW     = 4;
    localparam int RW     = $clog2(OUT_M);
    localparam int PW     = $clog2(IN_N);
    localparam int OUT_ID = 0;
`ifdef HOP_PRIO_EN
    localparam bit HOP_MODE = 1'b1;
`else
    localparam bit HOP_MODE = 1'b0;
`endif

    localparam logic [1:0] F_BODY = 2'b00;
    localparam logic [1:0] F_HEAD = 2'b01;
    localparam logic [1:0] F_TAIL = 2'b10;
    localparam logic [1:0] F_HT   = 2'b11;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [IN_N*RW-1:0]   rtr_res;
    logic [IN_N-1:0]      rtr_vld;
    logic [IN_N*HW-1:0]   hop;
    logic [IN_N*FW-1:0]   fid;
    logic [IN_N-1:0]      dvld;
    logic                 rdy;
    logic [PW-1:0]        sel;
    logic                 ovld;
    logic [IN_N-1:0]      alloc;

    always #5 clk = ~clk;

    wormhole_out_chan_arbiter #(
        .IN_N(IN_N), .OUT_M(OUT_M), .FLIT_ID_W(FW), .HOP_CNT_W(HW), .OUT_CHAN_ID(OUT_ID)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .rtr_res_i(rtr_res), .rtr_res_vld_i(rtr_vld),
        .hop_count_i(hop), .flit_id_i(fid), .data_vld_i(dvld), .forward_node_rdy_i(rdy),
        .sel_o(sel), .out_vld_o(ovld), .chan_alloc_o(alloc)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [2:0] dest;
        logic [3:0] hop;
    } tflit_t;

    tflit_t buf_q [IN_N][32];
    int     rd [IN_N];
    int     wr [IN_N];
    logic [IN_N-1:0] stall;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: the open path (-1 when the output is free), the crossbar
    // select last granted, and the round-robin start point.
    int m_path, m_sel, m_ptr;
    int cyc, xfers;
    int glog [32];
    int gn;
    logic [IN_N-1:0] prev_alloc;
    int last_tail [IN_N];
    int first_grant [IN_N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < IN_N; i++) begin
            tflit_t f;
            f = '0;
            if (rd[i] != wr[i]) f = buf_q[i][rd[i]];
            dvld[i]    = (rd[i] != wr[i]) && !stall[i];
            rtr_vld[i] = (rd[i] != wr[i]);
            fid[i*FW +: FW]     = f.id;
            rtr_res[i*RW +: RW] = f.dest[RW-1:0];
            hop[i*HW +: HW]     = f.hop;
        end
    endtask

    task automatic push(input int i, input logic [1:0] id, input int dest, input int h);
        tflit_t f;
        f.id   = id;
        f.dest = 3'(dest);
        f.hop  = 4'(h);
        buf_q[i][wr[i]] = f;
        wr[i]++;
    endtask

    task automatic model_clear();
        m_path = -1;
        m_sel  = 0;
        m_ptr  = 0;
        gn     = 0;
        prev_alloc = '0;
        stall  = '0;
        for (int i = 0; i < IN_N; i++) begin
            rd[i] = 0;
            wr[i] = 0;
            last_tail[i]   = -1;
            first_grant[i] = -1;
        end
    endtask

    function automatic logic [IN_N-1:0] m_requests();
        logic [IN_N-1:0] r;
        r = '0;
        for (int i = 0; i < IN_N; i++) begin
            logic [1:0] id;
            id = fid[i*FW +: FW];
            r[i] = dvld[i] && rtr_vld[i] && (rtr_res[i*RW +: RW] == RW'(OUT_ID))
                   && (id == F_HEAD || id == F_HT);
        end
        return r;
    endfunction

    // Highest hop score wins (score is 0 for all without hop priority);
    // among equal scores, the smallest clockwise distance from the pointer.
    function automatic int m_pick(input logic [IN_N-1:0] r, input int ptr);
        int best = -1;
        int best_h = -1;
        int best_d = IN_N;
        for (int i = 0; i < IN_N; i++) begin
            int h;
            int d;
            if (r[i]) begin
                h = HOP_MODE ? int'(hop[i*HW +: HW]) : 0;
                d = (i - ptr + IN_N) % IN_N;
                if (h > best_h || (h == best_h && d < best_d)) begin
                    best = i;
                    best_h = h;
                    best_d = d;
                end
            end
        end
        return best;
    endfunction

    task automatic cycle();
        logic [IN_N-1:0] exp_alloc;
        logic            exp_vld;
        logic [IN_N-1:0] pops;
        logic [IN_N-1:0] r;
        logic [1:0]      pid;
        int              n_path, n_sel, n_ptr, w;
        @(negedge clk);
        cyc++;
        exp_alloc = (m_path >= 0) ? (IN_N'(1) << m_path) : '0;
        exp_vld   = (m_path >= 0) && dvld[m_path] && rdy;
        check("chan_alloc", 32'(alloc), 32'(exp_alloc));
        check("out_vld", 32'(ovld), 32'(exp_vld));
        check("sel", 32'(sel), 32'(m_sel));
        for (int i = 0; i < IN_N; i++) begin
            if (alloc[i] && !prev_alloc[i]) begin
                if (gn < 32) glog[gn] = i;
                gn++;
                if (first_grant[i] < 0) first_grant[i] = cyc;
            end
            pid = fid[i*FW +: FW];
            if (ovld && alloc[i] && (pid == F_TAIL || pid == F_HT)) last_tail[i] = cyc;
        end
        prev_alloc = alloc;
        pops = ovld ? alloc : '0;
        n_path = m_path;
        n_sel  = m_sel;
        n_ptr  = m_ptr;
        if (m_path < 0) begin
            r = m_requests();
            if (r != '0) begin
                w = m_pick(r, m_ptr);
                n_path = w;
                n_sel  = w;
            end
        end else if (exp_vld) begin
            pid = fid[m_path*FW +: FW];
            if (pid == F_TAIL || pid == F_HT) begin
                n_path = -1;
                n_ptr  = (m_path + 1) % IN_N;
            end
        end
        @(posedge clk);
        #1;
        m_path = n_path;
        m_sel  = n_sel;
        m_ptr  = n_ptr;
        for (int i = 0; i < IN_N; i++) begin
            if (pops[i] && rd[i] != wr[i]) begin
                rd[i]++;
                xfers++;
            end
        end
        drive_inputs();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        rdy = 1'b1;
        drive_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int x0;
        cyc   = 0;
        xfers = 0;
        rdy   = 1'b1;
        model_clear();
        drive_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_alloc", 32'(alloc), 32'h0);
        check("reset_vld", 32'(ovld), 32'h0);
        check("reset_sel", 32'(sel), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single 3-flit packet from input 2, then rr_ptr=3 decides 1 vs 4.
        push(2, F_HEAD, OUT_ID, 0);
        push(2, F_BODY, OUT_ID, 0);
        push(2, F_TAIL, OUT_ID, 0);
        drive_inputs();
        cycle();
        check("single_grant", 32'(alloc), 32'h04);
        check("single_sel", 32'(sel), 32'd2);
        x0 = xfers;
        run(4);
        check("single_xfers", 32'(xfers - x0), 32'd3);
        push(1, F_HT, OUT_ID, 0);
        push(4, F_HT, OUT_ID, 0);
        drive_inputs();
        cycle();
        check("ptr_after_2", 32'(alloc), 32'h10);
        run(5);

        // Round robin among 0, 1 and 4 with back-to-back 2-flit packets.
        do_reset();
        for (int p = 0; p < 2; p++) begin
            push(0, F_HEAD, OUT_ID, 0); push(0, F_TAIL, OUT_ID, 0);
            push(1, F_HEAD, OUT_ID, 0); push(1, F_TAIL, OUT_ID, 0);
            push(4, F_HEAD, OUT_ID, 0); push(4, F_TAIL, OUT_ID, 0);
        end
        drive_inputs();
        x0 = xfers;
        run(22);
        check("rr_count", 32'(gn), 32'd6);
        check("rr_g0", 32'(glog[0]), 32'd0);
        check("rr_g1", 32'(glog[1]), 32'd1);
        check("rr_g2", 32'(glog[2]), 32'd4);
        check("rr_g3", 32'(glog[3]), 32'd0);
        check("rr_xfers", 32'(xfers - x0), 32'd12);

        // Backpressure, then owner buffer running dry mid-packet.
        do_reset();
        push(0, F_HEAD, OUT_ID, 0);
        for (int b = 0; b < 3; b++) push(0, F_BODY, OUT_ID, 0);
        push(0, F_TAIL, OUT_ID, 0);
        drive_inputs();
        x0 = xfers;
        run(2);
        rdy = 1'b0;
        drive_inputs();
        run(4);
        check("bp_hold_alloc", 32'(alloc), 32'h01);
        check("bp_hold_vld", 32'(ovld), 32'h0);
        rdy = 1'b1;
        stall[0] = 1'b1;
        drive_inputs();
        run(2);
        stall[0] = 1'b0;
        drive_inputs();
        run(6);
        check("bp_xfers", 32'(xfers - x0), 32'd5);
        check("bp_drained", 32'(wr[0] - rd[0]), 32'd0);

        // Lock: input 3 waits for input 1's tail plus one bubble.
        do_reset();
        push(1, F_HEAD, OUT_ID, 0);
        push(1, F_BODY, OUT_ID, 0);
        push(1, F_BODY, OUT_ID, 0);
        push(1, F_TAIL, OUT_ID, 0);
        drive_inputs();
        cycle();
        push(3, F_HEAD, OUT_ID, 0);
        push(3, F_TAIL, OUT_ID, 0);
        drive_inputs();
        run(9);
        check("lock_gap", 32'(first_grant[3] - last_tail[1]), 32'd2);
        do_reset();
        push(3, F_HT, 2, 0);
        drive_inputs();
        run(4);
        check("other_out_nogrant", 32'(first_grant[3]), 32'hFFFF_FFFF);

        // Hop priority: 7 beats 2 only when hop priority is built in.
        do_reset();
        push(0, F_HT, OUT_ID, 2);
        push(3, F_HT, OUT_ID, 7);
        drive_inputs();
        cycle();
        check("hop_winner", 32'(alloc), HOP_MODE ? 32'h08 : 32'h01);
        run(5);
        do_reset();
        push(0, F_HT, OUT_ID, 5);
        push(3, F_HT, OUT_ID, 5);
        drive_inputs();
        cycle();
        check("hop_tie", 32'(alloc), 32'h01);
        run(5);

        // Asynchronous reset in the middle of input 2's packet.
        do_reset();
        push(2, F_HEAD, OUT_ID, 0);
        push(2, F_BODY, OUT_ID, 0);
        push(2, F_TAIL, OUT_ID, 0);
        drive_inputs();
        run(2);
        check("pre_arst_sel", 32'(sel), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check("arst_alloc", 32'(alloc), 32'h0);
        check("arst_vld", 32'(ovld), 32'h0);
        check("arst_sel", 32'(sel), 32'h0);
        model_clear();
        push(4, F_HT, OUT_ID, 0);
        drive_inputs();
        #1 rst_n = 1'b1;
        cycle();
        check("post_arst_grant", 32'(alloc), 32'h10);
        check("post_arst_vld", 32'(ovld), 32'h1);
        run(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wormhole_out_chan_arbiter.md
# wormhole_out_chan_arbiter

Per-output-channel wormhole arbiter for the 2D mesh node: one instance sits in front of each output port of the parallel crossbar. It picks one input channel whose routed head flit targets this output, holds that input-to-output path for the whole packet (head to tail), and drives the crossbar select and the per-input grant vector. Winner selection is round-robin, optionally biased by hop count.

## Interface
- IN_N, 5, number of input channels
- OUT_M, 5, number of output channels
- FLIT_ID_W, 2, flit type field width
- HOP_CNT_W, 4, hop count width
- OUT_CHAN_ID, 0, index of the output port this instance serves
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- rtr_res_i  in  IN_N*$clog2(OUT_M)  packed route result per input
- rtr_res_vld_i  in  IN_N  route result valid per input
- hop_count_i  in  IN_N*HOP_CNT_W  header hop count per input
- flit_id_i  in  IN_N*FLIT_ID_W  type of the flit at each input head
- data_vld_i  in  IN_N  input buffer non-empty
- forward_node_rdy_i  in  1  downstream buffer not full
- sel_o  out  $clog2(IN_N)  crossbar select for this output
- out_vld_o  out  1  flit transferred this cycle
- chan_alloc_o  out  IN_N  one-hot grant to owning input (pop enable)

## Operation
- Flit IDs: BODY=2'b00, HEAD=2'b01, TAIL=2'b10, HEAD_TAIL=2'b11 (single-flit packet).
- Request: req[i] = data_vld_i[i] & rtr_res_vld_i[i] & (rtr_res_i[i]==OUT_CHAN_ID) & flit_id_i[i] in {HEAD, HEAD_TAIL}.
- FSM states: IDLE and BUSY.
- IDLE, with any req: register winner into owner, set chan_alloc_o to one-hot(owner), and go to BUSY. With no req, stay in IDLE.
- Winner is the first requester at or after rr_ptr, wrapping modulo IN_N.
- BUSY:
  - sel_o = owner.
  - out_vld_o = data_vld_i[owner] & forward_node_rdy_i. This is combinational from the registered owner.
  - Each cycle where out_vld_o=1 is one flit transfer.
- Leaving BUSY: on a transfer whose flit_id_i[owner] is TAIL or HEAD_TAIL, go to IDLE. In the same edge, clear chan_alloc_o and set rr_ptr = (owner+1) mod IN_N.
- In BUSY, the owner's flit_id is not checked apart from TAIL/HEAD_TAIL. A stray HEAD is forwarded as a body flit.
- Requests from non-owners are ignored while BUSY.
- rr_ptr updates only on packet completion.

## Timing
- Reset values: state IDLE, rr_ptr 0, owner 0, sel_o 0, chan_alloc_o 0, out_vld_o 0.
- Grant latency:
  - Head presented in cycle n gives chan_alloc_o in cycle n+1.
  - The first transfer is possible in cycle n+1.
- Throughput: 1 flit/cycle while the owner is valid and downstream is ready.
- Packet turnaround: the tail transfers in cycle t, state is IDLE in t+1, and the next grant is in t+2. There is exactly one bubble cycle, even if requests are pending.
- Owner data_vld_i low mid-packet: stay BUSY, out_vld_o=0, path held indefinitely.
- forward_node_rdy_i low: out_vld_o=0. Grant and sel_o are held with no flit lost.
- rst_ni asserted mid-packet: all outputs go to reset values immediately (async). A packet in flight is abandoned.
- sel_o is stable throughout BUSY and changes only on the edge that enters BUSY.

## Configuration
- HOP_PRIO_EN defined:
  - The winner is the requester with the largest hop_count_i. This is an unsigned compare.
  - Ties go to the first tied requester at or after rr_ptr.
- HOP_PRIO_EN undefined: pure round-robin, and hop_count_i is unused.
- FSM, latency and lock behaviour are identical in both builds.

## Structure
- Shared package/include mesh_wormhole_pkg:
  - flit ID constants FLIT_BODY, FLIT_HEAD, FLIT_TAIL, FLIT_HEAD_TAIL
  - state encodings ARB_IDLE, ARB_BUSY
- Sub-module rr_prio_select: combinational. It takes the request vector, rr_ptr and packed hop counts, and returns the winner index plus an any-request flag. Hop compare logic is inside `ifdef HOP_PRIO_EN.
- Top holds the FSM, owner, rr_ptr and the grant register.

## Test plan
- Single packet: input 2 sends HEAD, BODY, TAIL to OUT_CHAN_ID with ready=1.
  - Required: chan_alloc_o=5'b00100 one cycle after the head.
  - Required: sel_o=2 and out_vld_o high for 3 cycles, then IDLE with rr_ptr=3.
- Round-robin: inputs 0, 1 and 4 each send 2-flit packets continuously from reset.
  - Required: grant order is 0, 1, 4, 0, with one bubble between packets.
- Backpressure: forward_node_rdy_i low for 4 cycles mid-packet.
  - Required: out_vld_o=0 and sel_o/chan_alloc_o unchanged.
  - Required: transfer resumes with no flit dropped or duplicated.
- Lock: during input 1's packet, input 3 raises a head for the same output.
  - Required: no grant to 3 until two cycles after input 1's tail.
  - Required: input 3's head targeting a different OUT_CHAN_ID never requests.
- HOP_PRIO_EN: inputs 0 and 3 request simultaneously with rr_ptr=0 and hops 2 and 7.
  - Required: 3 wins.
  - Required: with equal hops, 0 wins. Without the macro, 0 wins regardless of hops.
- Async reset mid-packet: rst_ni pulsed low between edges.
  - Required: outputs go to 0 without waiting for a clock edge.
  - Required: afterwards the arbiter is IDLE and accepts a new HEAD_TAIL from input 4 with the normal 1-cycle grant latency.
